uart_tx_frame: RTL and testbench

Parametrised, self-contained UART transmitter for the next-generation serial TX path. Control FSM, shift register, parity generator and per-bit prescaler are merged into one block. Data width, parity type, stop-bit count and bit period are configurable, and back-to-back frames are supported without an idle gap. The block sits between the register/FIFO front end, which drives P_DATA/DATA_VALID, and the TX pad.

---
 rtl/uart_tx_frame.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//
// Parametrised UART transmitter. A single block holds the control FSM, the
// payload shift register, the parity generator and the per-bit prescaler.
// Frames are: start (0), DATA_WIDTH payload bits LSB first, optional parity,
// one or two stop bits (1). A new request can be accepted on the last clock
// of the final stop bit, so back-to-back frames have no idle gap.
//
// Parameters
//   DATA_WIDTH  payload bits per frame (5..9)
//   PRESCALE    clocks per serial bit (>= 1)
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous, active-high reset
//   P_DATA      parallel payload, sampled on accept
//   DATA_VALID  request to send P_DATA
//   PAR_EN      1 = append parity bit, sampled on accept
//   PAR_TYP     0 = even, 1 = odd parity, sampled on accept
//   STOP2       0 = one stop bit, 1 = two stop bits, sampled on accept
//   TX_OUT      registered serial line, idle high
//   BUSY        registered, high while a frame is on the line
//   DATA_ACK    registered one-cycle pulse when P_DATA is accepted
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DATA_ACK
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]            state;
  logic [PW-1:0]         presc_cnt;
  logic [3:0]            bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop2_q;

  logic bit_end;
  logic stop_final;
  logic accept;

  // Last clock of the current serial bit.
  assign bit_end    = (presc_cnt == PW'(PRESCALE - 1));
  // Last clock of the last stop bit: the slot where a back-to-back frame may start.
  assign stop_final = (state == ST_STOP) && bit_end && (stop_cnt == stop2_q);
  assign accept     = DATA_VALID && ((state == ST_IDLE) || stop_final);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      presc_cnt <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      // NOTE: the shift register is cleared on reset so a frame aborted
      // mid-way leaves no stale payload behind; it is a handful of flops,
      // not a memory array, so the reset is cheap.
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
      DATA_ACK  <= 1'b0;
    end else begin
      DATA_ACK <= 1'b0;
      if (accept) begin
        shift_reg <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
        stop2_q   <= STOP2;
        state     <= ST_START;
        presc_cnt <= '0;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
        TX_OUT    <= 1'b0;
        BUSY      <= 1'b1;
        DATA_ACK  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            presc_cnt <= '0;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
          end
          ST_START: begin
            if (bit_end) begin
              state     <= ST_DATA;
              presc_cnt <= '0;
              TX_OUT    <= shift_reg[0];
            end else begin
              presc_cnt <= presc_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (bit_end) begin
              presc_cnt <= '0;
              if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
                bit_cnt <= '0;
                if (par_en_q) begin
                  state  <= ST_PARITY;
                  TX_OUT <= par_bit_q;
                end else begin
                  state    <= ST_STOP;
                  stop_cnt <= 1'b0;
                  TX_OUT   <= 1'b1;
                end
              end else begin
                // Register the next bit directly so TX_OUT never glitches
                // between the shift and the output update.
                bit_cnt   <= bit_cnt + 1'b1;
                shift_reg <= shift_reg >> 1;
                TX_OUT    <= shift_reg[1];
              end
            end else begin
              presc_cnt <= presc_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (bit_end) begin
              state     <= ST_STOP;
              presc_cnt <= '0;
              stop_cnt  <= 1'b0;
              TX_OUT    <= 1'b1;
            end else begin
              presc_cnt <= presc_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (bit_end) begin
              presc_cnt <= '0;
              if (stop_cnt == stop2_q) begin
                state    <= ST_IDLE;
                stop_cnt <= 1'b0;
                BUSY     <= 1'b0;
                TX_OUT   <= 1'b1;
              end else begin
                stop_cnt <= 1'b1;
              end
            end else begin
              presc_cnt <= presc_cnt + 1'b1;
            end
          end
          default: begin
            // Unreachable encodings fall back to a quiet, idle line.
            state     <= ST_IDLE;
            presc_cnt <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Two transmitters share one stimulus stream: instance A (8-bit payload,
// 1 clock per bit) and instance B (5-bit payload, 3 clocks per bit). A
// frame-level model tracks, per instance, the position inside the frame on
// the line and derives the expected TX_OUT/BUSY/DATA_ACK from the frame
// layout arithmetic. A negedge process compares every cycle; directed
// sequences pin the model with hand-written bit patterns.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int A_DW = 8;
  localparam int A_P  = 1;
  localparam int B_DW = 5;
  localparam int B_P  = 3;

  logic       CLK;
  logic       RST;
  logic [7:0] p_data;
  logic       dv;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic       tx_a, busy_a, ack_a;
  logic       tx_b, busy_b, ack_b;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  uart_tx_frame #(.DATA_WIDTH(A_DW), .PRESCALE(A_P)) u_a (
    .CLK(CLK), .RST(RST), .P_DATA(p_data[A_DW-1:0]), .DATA_VALID(dv),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_a), .BUSY(busy_a), .DATA_ACK(ack_a)
  );

  uart_tx_frame #(.DATA_WIDTH(B_DW), .PRESCALE(B_P)) u_b (
    .CLK(CLK), .RST(RST), .P_DATA(p_data[B_DW-1:0]), .DATA_VALID(dv),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_b), .BUSY(busy_b), .DATA_ACK(ack_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- frame model -------------------------------------------------------
  function automatic int frame_len(int dw, int presc, bit pe, bit s2);
    return presc * (2 + dw + int'(pe) + int'(s2));
  endfunction

  // Line level at clock n of a frame: slot 0 start, 1..dw payload LSB first,
  // optional parity slot, then stop slots.
  function automatic bit frame_bit(int dw, int presc, logic [7:0] d, bit pe, bit pt, int n);
    int slot;
    bit par;
    slot = n / presc;
    par  = pt;
    for (int i = 0; i < dw; i++) par ^= d[i];
    if (slot == 0) return 1'b0;
    if (slot <= dw) return d[slot-1];
    if (pe && slot == dw + 1) return par;
    return 1'b1;
  endfunction

  int         a_pos = 0, a_len = 0;
  logic [7:0] a_d;
  bit         a_pe, a_pt, a_ack, a_acc;
  int         b_pos = 0, b_len = 0;
  logic [7:0] b_d;
  bit         b_pe, b_pt, b_ack, b_acc;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_pos = 0; a_len = 0; a_ack = 0;
    end else begin
      a_acc = dv && (a_pos >= a_len || a_pos == a_len - 1);
      if (a_acc) begin
        a_d = p_data; a_pe = par_en; a_pt = par_typ;
        a_pos = 0; a_len = frame_len(A_DW, A_P, par_en, stop2);
      end else if (a_pos < a_len) begin
        a_pos++;
      end
      a_ack = a_acc;
    end
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      b_pos = 0; b_len = 0; b_ack = 0;
    end else begin
      b_acc = dv && (b_pos >= b_len || b_pos == b_len - 1);
      if (b_acc) begin
        b_d = p_data; b_pe = par_en; b_pt = par_typ;
        b_pos = 0; b_len = frame_len(B_DW, B_P, par_en, stop2);
      end else if (b_pos < b_len) begin
        b_pos++;
      end
      b_ack = b_acc;
    end
  end

  logic [2:0] exp_a, exp_b;
  always @(negedge CLK) begin
    if (cmp_en) begin
      exp_a = {(a_pos < a_len) ? frame_bit(A_DW, A_P, a_d, a_pe, a_pt, a_pos) : 1'b1,
               a_pos < a_len, a_ack};
      exp_b = {(b_pos < b_len) ? frame_bit(B_DW, B_P, b_d, b_pe, b_pt, b_pos) : 1'b1,
               b_pos < b_len, b_ack};
      check("A_cycle_tx_busy_ack", {tx_a, busy_a, ack_a}, exp_a);
      check("B_cycle_tx_busy_ack", {tx_b, busy_b, ack_b}, exp_b);
    end
  end

  // ---- directed helpers --------------------------------------------------
  task automatic wait_idle();
    for (int i = 0; i < 200 && (busy_a || busy_b); i++) @(negedge CLK);
    check("idle_wait", {busy_a, busy_b}, 2'b00);
  endtask

  // Sends one frame and compares the selected instance against a literal
  // slot pattern (MSB = start bit), each slot held for that instance's prescale.
  task automatic run_frame(input bit sel, input logic [7:0] d, input bit pe, input bit pt,
                           input bit s2, input logic [15:0] slots, input int nslots,
                           input string name);
    logic [63:0] cap, exp;
    int nb, na, presc, nclk;
    bit t;
    wait_idle();
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2; dv = 1'b1;
    @(negedge CLK);
    dv = 1'b0;
    presc = sel ? B_P : A_P;
    nclk  = nslots * presc;
    cap = '0; exp = '0; nb = 0; na = 0;
    for (int i = 0; i <= nclk; i++) begin
      if (i > 0) @(negedge CLK);
      t   = sel ? tx_b : tx_a;
      cap = {cap[62:0], t};
      exp = {exp[62:0], (i < nclk) ? slots[nslots - 1 - i / presc] : 1'b1};
      nb += sel ? int'(busy_b) : int'(busy_a);
      na += sel ? int'(ack_b) : int'(ack_a);
    end
    check({name, "_tx"}, cap, exp);
    check({name, "_busy_clks"}, nb, nclk);
    check({name, "_acks"}, na, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap, drops, acks, nb;
    bit got;
    RST = 1'b1; dv = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_A", {tx_a, busy_a, ack_a}, 3'b100);
    check("reset_B", {tx_b, busy_b, ack_b}, 3'b100);
    RST = 1'b0;
    cmp_en = 1'b1;
    @(negedge CLK);

    // 0xA5, even parity, one stop.
    run_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 16'b01010010101, 11, "a5_even");
    // 0x01, odd parity (bit = 0), two stops.
    run_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 16'b010000011, 9, "b01_odd_2stop");
    // 5-bit payload 10011, even parity (bit = 1).
    run_frame(1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 16'b01100111, 8, "w5_10011");

    // Back-to-back with DATA_VALID held high.
    wait_idle();
    p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; dv = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge CLK); got = ack_a; end
    check("b2b_first_ack", got, 1);
    p_data = 8'h0F;
    gap = 0; drops = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      gap++;
      got = ack_a;
      if (!busy_a) drops++;
    end
    dv = 1'b0;
    check("b2b_ack_gap", gap, 10);
    check("b2b_busy_drops", drops, 0);

    // Mid-frame request and option changes are ignored.
    wait_idle();
    p_data = 8'h0A; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; dv = 1'b1;
    @(negedge CLK);
    dv = 1'b0;
    acks = 0; nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin
        @(negedge CLK);
        acks += int'(ack_a) + int'(ack_b);
      end
      nb += int'(busy_b);
      if (i == 5) begin dv = 1'b1; par_en = 1'b0; par_typ = 1'b1; stop2 = 1'b1; end
      if (i == 7) dv = 1'b0;
    end
    check("midframe_no_ack", acks, 0);
    check("midframe_b_len", nb, 24);

    // Asynchronous reset in the third data bit of instance B.
    wait_idle();
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; dv = 1'b1;
    @(negedge CLK);
    dv = 1'b0;
    repeat (9) @(negedge CLK);
    check("pre_rst_b_busy", busy_b, 1);
    #2 RST = 1'b1;
    #1;
    check("rst_async_b", {tx_b, busy_b}, 2'b10);
    check("rst_async_a", {tx_a, busy_a}, 2'b10);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    run_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 16'b0001111001, 10, "post_rst_a3c");
    run_frame(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 16'b0001111, 7, "post_rst_b3c");

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      dv      = ($urandom_range(0, 99) < 35);
      p_data  = 8'($urandom);
      par_en  = 1'($urandom_range(0, 1));
      par_typ = 1'($urandom_range(0, 1));
      stop2   = 1'($urandom_range(0, 1));
      if (c == 1500) begin
        #2 RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
      end
    end
    dv = 1'b0;
    wait_idle();
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
